// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Purpose  : Shared definitions for the SDRAM word responder and the io_sdram
//            wrapper: FSM state encoding, the default word returned by an
//            aborted read, and the lo/hi half-word address offsets.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WR_LO   = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_WR_HI   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_RD_LO   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_RD_HI   = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_RD_WAIT = 3'd5;

    localparam logic [31:0] c_TIMEOUT_DATA_DEFAULT = 32'hDEADBEEF;

    // Half-word address LSB: word[15:0] lives at {addr,0}, word[31:16] at {addr,1}.
    localparam logic c_HW_LO_OFFSET = 1'b0;
    localparam logic c_HW_HI_OFFSET = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sdram_word_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_word_responder
// Purpose  : Converts single-cycle 32-bit word read/write pulses from the CPU
//            into two 16-bit commands (lo first) on the SDRAM controller's
//            half-word port, and reassembles pipelined read responses.
// Ports    : clk/reset            - system clock, async active-high reset
//            word_*               - CPU word interface (rd/wr pulses, busy,
//                                   rdata + one-cycle rdata_valid)
//            cmd_*                - half-word command port (valid/ready)
//            rsp_valid/rsp_data   - in-order read responses
//            err_clear/err_*      - sticky overrun / timeout flags
// Revision : 1.0 - initial release
// ============================================================================
module sdram_word_responder
    import sdram_pkg::*;
#(
    parameter int          ADDR_W       = 24,
    parameter int          TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_DATA = c_TIMEOUT_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_rd,
    input  logic              word_wr,
    input  logic [ADDR_W-1:0] word_addr,
    input  logic [31:0]       word_wdata,
    output logic              word_busy,
    output logic [31:0]       word_rdata,
    output logic              word_rdata_valid,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W:0]   cmd_addr,
    output logic [15:0]       cmd_wdata,
    input  logic              rsp_valid,
    input  logic [15:0]       rsp_data,
    input  logic              err_clear,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int                 c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX  = c_TMO_W'(TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_STATE_W-1:0] state_q,       state_d;
    logic [ADDR_W-1:0]    addr_q,        addr_d;
    logic [31:0]          wdata_q,       wdata_d;
    logic [15:0]          lo_q,          lo_d;
    logic [31:0]          rdata_q,       rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic [1:0]           rcv_q,         rcv_d;
    logic [1:0]           stale_q,       stale_d;
    logic [c_TMO_W-1:0]   tmo_q,         tmo_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 err_timeout_q, err_timeout_d;

    logic       w_busy;
    logic       w_xfer;
    logic       w_rd_state;
    logic       w_live_rsp;
    logic       w_timeout;
    logic       w_overrun_set;
    logic [1:0] w_accepted;
    logic [2:0] w_stale_sum;

    // ------------------------------------------------------------------------
    // State / datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= c_ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            lo_q          <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rcv_q         <= '0;
            stale_q       <= '0;
            tmo_q         <= '0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            lo_q          <= lo_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rcv_q         <= rcv_d;
            stale_q       <= stale_d;
            tmo_q         <= tmo_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        lo_d          = lo_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        rcv_d         = rcv_q;
        stale_d       = stale_q;
        tmo_d         = tmo_q;

        w_busy     = (state_q != c_ST_IDLE);
        w_xfer     = cmd_valid & cmd_ready;
        w_rd_state = (state_q == c_ST_RD_LO) || (state_q == c_ST_RD_HI) ||
                     (state_q == c_ST_RD_WAIT);
        // Responses owed to an aborted read are swallowed before anything else.
        w_live_rsp = rsp_valid && (stale_q == 2'd0) && w_rd_state;
        w_timeout  = w_rd_state && !w_xfer && !rsp_valid && (tmo_q >= c_TMO_LAST);

        // Read commands already accepted for the read in progress.
        case (state_q)
            c_ST_RD_HI:   w_accepted = 2'd1;
            c_ST_RD_WAIT: w_accepted = 2'd2;
            default:      w_accepted = 2'd0;
        endcase
        w_stale_sum = {1'b0, stale_q} + {1'b0, w_accepted} - {1'b0, rcv_q};

        w_overrun_set = w_busy ? (word_rd | word_wr) : (word_rd & word_wr);

        case (state_q)
            c_ST_IDLE: begin
                if (word_wr) begin
                    addr_d  = word_addr;
                    wdata_d = word_wdata;
                    state_d = c_ST_WR_LO;
                end else if (word_rd) begin
                    addr_d  = word_addr;
                    rcv_d   = 2'd0;
                    state_d = c_ST_RD_LO;
                end
            end
            c_ST_WR_LO:   if (w_xfer) state_d = c_ST_WR_HI;
            c_ST_WR_HI:   if (w_xfer) state_d = c_ST_IDLE;
            c_ST_RD_LO:   if (w_xfer) state_d = c_ST_RD_HI;
            c_ST_RD_HI:   if (w_xfer) state_d = c_ST_RD_WAIT;
            c_ST_RD_WAIT: state_d = state_q;
            default:      state_d = c_ST_IDLE;
        endcase

        if (rsp_valid && (stale_q != 2'd0)) begin
            stale_d = stale_q - 2'd1;
        end

        if (w_live_rsp) begin
            if (rcv_q == 2'd0) begin
                lo_d  = rsp_data;
                rcv_d = 2'd1;
            end else begin
                // word_rdata only changes when a whole word is ready.
                rdata_d       = {rsp_data, lo_q};
                rdata_valid_d = 1'b1;
                rcv_d         = 2'd0;
                state_d       = c_ST_IDLE;
            end
        end else if (w_timeout) begin
            rdata_d       = TIMEOUT_DATA;
            rdata_valid_d = 1'b1;
            rcv_d         = 2'd0;
            stale_d       = (w_stale_sum > 3'd2) ? 2'd2 : w_stale_sum[1:0];
            state_d       = c_ST_IDLE;
        end

        // Progress counter: idle outside reads, cleared by any activity.
        if (!w_rd_state || w_xfer || rsp_valid || w_timeout) begin
            tmo_d = '0;
        end else if (tmo_q != c_TMO_MAX) begin
            tmo_d = tmo_q + c_TMO_W'(1);
        end

        // A set event in the same cycle as err_clear keeps the flag set.
        err_overrun_d = w_overrun_set | (err_overrun_q & ~err_clear);
        err_timeout_d = w_timeout     | (err_timeout_q & ~err_clear);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        word_busy        = (state_q != c_ST_IDLE);
        word_rdata       = rdata_q;
        word_rdata_valid = rdata_valid_q;
        err_overrun      = err_overrun_q;
        err_timeout      = err_timeout_q;

        cmd_valid = (state_q == c_ST_WR_LO) || (state_q == c_ST_WR_HI) ||
                    (state_q == c_ST_RD_LO) || (state_q == c_ST_RD_HI);
        cmd_we    = (state_q == c_ST_WR_LO) || (state_q == c_ST_WR_HI);
        cmd_addr  = '0;
        cmd_wdata = '0;
        if (cmd_valid) begin
            cmd_addr = {addr_q, ((state_q == c_ST_WR_HI) || (state_q == c_ST_RD_HI))
                                ? c_HW_HI_OFFSET : c_HW_LO_OFFSET};
        end
        if (state_q == c_ST_WR_LO) cmd_wdata = wdata_q[15:0];
        if (state_q == c_ST_WR_HI) cmd_wdata = wdata_q[31:16];
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_word_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_word_responder
// Purpose  : Self-checking bench for sdram_word_responder. A behavioural
//            controller model with half-word memory answers commands; a
//            word-level model predicts commands and read words into queues
//            that a negedge monitor pops whenever the DUT presents output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_word_responder;

    localparam int          ADDR_W  = 24;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] TDATA   = 32'hDEADBEEF;

    logic              clk, reset;
    logic              word_rd, word_wr;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       word_wdata;
    logic              word_busy;
    logic [31:0]       word_rdata;
    logic              word_rdata_valid;
    logic              cmd_valid, cmd_ready, cmd_we;
    logic [ADDR_W:0]   cmd_addr;
    logic [15:0]       cmd_wdata;
    logic              rsp_valid;
    logic [15:0]       rsp_data;
    logic              err_clear, err_overrun, err_timeout;

    sdram_word_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TIMEOUT_DATA(TDATA)) dut (
        .clk(clk), .reset(reset),
        .word_rd(word_rd), .word_wr(word_wr), .word_addr(word_addr), .word_wdata(word_wdata),
        .word_busy(word_busy), .word_rdata(word_rdata), .word_rdata_valid(word_rdata_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .err_clear(err_clear), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic we; logic [ADDR_W:0] addr; logic [15:0] wdata; } cmd_t;
    typedef struct { int due; logic [15:0] data; } rsp_t;

    int checks = 0;
    int errors = 0;
    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd[$];
    rsp_t        pend[$];
    logic [31:0] wmem [logic [ADDR_W-1:0]];
    logic [15:0] hmem [logic [ADDR_W:0]];
    int ready_mode = 0;   // 0: ready high, 1: random, 2: held low
    int lat_min = 2, lat_max = 2;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Contents of never-written memory, as a function of the half-word address.
    function automatic logic [15:0] hdef(input logic [ADDR_W:0] a);
        return a[15:0] ^ {7'h0, a[ADDR_W:16]} ^ 16'h3C5A;
    endfunction

    function automatic logic [31:0] word_expect(input logic [ADDR_W-1:0] a);
        if (wmem.exists(a)) return wmem[a];
        return {hdef({a, 1'b1}), hdef({a, 1'b0})};
    endfunction

    // ------------------------------------------------------------------------
    // Monitor + controller bookkeeping (negedge, away from the active edge)
    // ------------------------------------------------------------------------
    initial begin
        logic        prev_valid, prev_stall;
        logic [41:0] prev_fields;
        int          last_due;
        cmd_t        c;
        rsp_t        r;
        prev_valid = 0; prev_stall = 0; prev_fields = '0; last_due = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 0; prev_stall = 0; last_due = 0;
                continue;
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", {cmd_we, cmd_addr}, 64'h0);
                end else begin
                    c = exp_cmd.pop_front();
                    check("cmd_we", cmd_we, c.we);
                    check("cmd_addr", cmd_addr, c.addr);
                    if (c.we) check("cmd_wdata", cmd_wdata, c.wdata);
                end
                if (cmd_we) begin
                    hmem[cmd_addr] = cmd_wdata;
                end else begin
                    r.data = hmem.exists(cmd_addr) ? hmem[cmd_addr] : hdef(cmd_addr);
                    r.due  = cyc + int'($urandom_range(lat_min, lat_max));
                    if (r.due <= last_due) r.due = last_due + 1;
                    last_due = r.due;
                    pend.push_back(r);
                end
            end
            if (prev_stall) begin
                check("cmd_hold_valid", cmd_valid, 1'b1);
                check("cmd_hold_fields", {cmd_we, cmd_addr, cmd_wdata}, prev_fields);
            end
            prev_stall  = cmd_valid && !cmd_ready;
            prev_fields = {cmd_we, cmd_addr, cmd_wdata};
            if (word_rdata_valid) begin
                check("rdata_busy_low", word_busy, 1'b0);
                check("rdata_pulse_width", prev_valid, 1'b0);
                if (exp_rd.size() == 0) check("rdata_unexpected", word_rdata, 64'h0);
                else                    check("word_rdata", word_rdata, exp_rd.pop_front());
            end
            prev_valid = word_rdata_valid;
        end
    end

    // ------------------------------------------------------------------------
    // Controller drive: cmd_ready and in-order responses
    // ------------------------------------------------------------------------
    initial begin
        rsp_t r;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (reset) begin
                pend.delete();
                rsp_valid = 1'b0;
            end else if (pend.size() != 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                rsp_valid = 1'b1;
                rsp_data  = r.data;
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = 16'($urandom);
            end
            case (ready_mode)
                0:       cmd_ready = 1'b1;
                1:       cmd_ready = ($urandom_range(0, 9) >= 3);
                default: cmd_ready = 1'b0;
            endcase
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic tmo);
        cmd_t c;
        word_rd = rd; word_wr = wr; word_addr = a; word_wdata = d;
        if (wr) begin
            c.we = 1'b1; c.addr = {a, 1'b0}; c.wdata = d[15:0];  exp_cmd.push_back(c);
            c.we = 1'b1; c.addr = {a, 1'b1}; c.wdata = d[31:16]; exp_cmd.push_back(c);
            wmem[a] = d;
        end else if (rd) begin
            c.we = 1'b0; c.addr = {a, 1'b0}; c.wdata = '0; exp_cmd.push_back(c);
            c.we = 1'b0; c.addr = {a, 1'b1}; c.wdata = '0; exp_cmd.push_back(c);
            exp_rd.push_back(tmo ? TDATA : word_expect(a));
        end
        @(posedge clk); #1;
        word_rd = 1'b0; word_wr = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (word_busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check("busy_release", word_busy, 1'b0);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        cycles(1);
        err_clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [ADDR_W-1:0] a;
        reset = 1'b1; word_rd = 0; word_wr = 0; word_addr = '0; word_wdata = '0; err_clear = 0;
        cycles(3);
        check("rst_busy", word_busy, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_rdata", {word_rdata_valid, word_rdata}, 64'h0);
        check("rst_errs", {err_overrun, err_timeout}, 2'b00);
        reset = 1'b0;
        cycles(2);

        // Directed write, ready always high.
        issue(0, 1, 24'h000123, 32'hCAFEBABE, 0);
        wait_idle(n);
        check("wr_busy_cycles", n, 2);

        // Directed read with 2-cycle responses 0x1234 / 0xABCD.
        hmem[{24'h000010, 1'b0}] = 16'h1234;
        hmem[{24'h000010, 1'b1}] = 16'hABCD;
        wmem[24'h000010] = 32'hABCD1234;
        issue(1, 0, 24'h000010, 32'h0, 0);
        wait_idle(n);
        check("rd_busy_cycles", n, 4);
        lat_min = 1; lat_max = 4;

        // Backpressure: lo write command held for 5 cycles.
        ready_mode = 2;
        cycles(1);
        issue(0, 1, 24'h0ABCDE, 32'h13579BDF, 0);
        cycles(4);
        check("bp_busy_held", {word_busy, cmd_valid}, 2'b11);
        ready_mode = 0;
        wait_idle(n);

        // Overrun during a write, err_clear, clear-vs-set priority, rd+wr together.
        ready_mode = 2;
        cycles(1);
        issue(0, 1, 24'h000200, 32'h0BADF00D, 0);
        word_rd = 1'b1; cycles(1); word_rd = 1'b0;
        check("overrun_set", err_overrun, 1'b1);
        word_wr = 1'b1; err_clear = 1'b1; cycles(1); word_wr = 1'b0; err_clear = 1'b0;
        check("overrun_set_beats_clear", err_overrun, 1'b1);
        ready_mode = 0;
        wait_idle(n);
        pulse_clear();
        check("overrun_cleared", err_overrun, 1'b0);
        issue(1, 1, 24'h000201, 32'h89ABCDEF, 0);
        wait_idle(n);
        check("rdwr_busy_cycles", n, 2);
        check("rdwr_overrun", err_overrun, 1'b1);
        pulse_clear();

        // Timeout, late responses arriving in IDLE, then a normal read.
        issue(0, 1, 24'h000300, 32'hAAAA5555, 0);
        wait_idle(n);
        lat_min = 20; lat_max = 20;
        issue(1, 0, 24'h000301, 32'h0, 1);
        wait_idle(n);
        check("tmo_busy_cycles", n, TIMEOUT + 2);
        check("tmo_flag", err_timeout, 1'b1);
        lat_min = 1; lat_max = 4;
        cycles(10);
        issue(1, 0, 24'h000300, 32'h0, 0);
        wait_idle(n);
        pulse_clear();
        check("tmo_cleared", err_timeout, 1'b0);

        // Timeout, late responses arriving during the next read.
        lat_min = 20; lat_max = 20;
        issue(1, 0, 24'h000301, 32'h0, 1);
        wait_idle(n);
        lat_min = 1; lat_max = 4;
        issue(1, 0, 24'h000300, 32'h0, 0);
        wait_idle(n);
        pulse_clear();

        // Reset asserted mid-cycle while waiting for read responses.
        lat_min = 20; lat_max = 20;
        issue(1, 0, 24'h000300, 32'h0, 0);
        cycles(3);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {word_busy, cmd_valid, word_rdata_valid}, 3'b000);
        check("arst_rdata", word_rdata, 32'h0);
        exp_rd.delete();
        exp_cmd.delete();
        cycles(3);
        reset = 1'b0;
        lat_min = 1; lat_max = 4;
        cycles(1);
        issue(0, 1, 24'h000400, 32'h2468ACE0, 0);
        wait_idle(n);
        check("post_rst_wr_cycles", n, 2);
        issue(1, 0, 24'h000400, 32'h0, 0);
        wait_idle(n);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 80; i++) begin
            ready_mode = int'($urandom_range(0, 1));
            cycles(1);
            a = 24'h000040 + 24'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                issue(0, 1, a, $urandom, 0);
                wait_idle(n);
            end else begin
                issue(1, 0, a, 32'h0, 0);
                wait_idle(n);
                check("rd_min_latency", (n >= 3), 1'b1);
            end
        end
        ready_mode = 0;

        cycles(10);
        check("rd_queue_drained", exp_rd.size(), 0);
        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("final_errs", {err_overrun, err_timeout}, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
